// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Pipeline hazard detection and forwarding-select generator for a 5-stage
// in-order core. Three shadow records (EX, MEM, WB) track the destination
// information of instructions that have left ID. From these the unit:
//   - registers forwarding selects for EX operands A/B (one-cycle latency,
//     valid for the whole EX cycle of the instruction they belong to);
//   - detects load-use hazards and stalls IF/ID for exactly one cycle;
//   - flushes ID/EX on a taken branch (flush beats stall).
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   id_valid                ID holds a real instruction
//   id_rs1/id_rs2           ID source registers, id_uses_rs1/2 qualify them
//   id_rd, id_reg_write     ID destination and write enable
//   id_mem_read, id_is_link ID is a load / a JAL(R) writing PC+4
//   ex_branch_taken         EX resolved a taken branch/jump this cycle
//   fwd_a_sel, fwd_b_sel    registered select: 00 RF, 01 EX/MEM ALU,
//                           10 MEM/WB data, 11 EX/MEM PC+4
//   stall_if_id, pc_write_en, flush_id_ex  combinational pipeline controls
module hazard_forward_unit (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] id_rd,
  input  logic       id_reg_write,
  input  logic       id_mem_read,
  input  logic       id_is_link,
  input  logic       ex_branch_taken,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel,
  output logic       stall_if_id,
  output logic       pc_write_en,
  output logic       flush_id_ex
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       is_link;
  } rec_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam rec_t BUBBLE = '{valid: 1'b0, rd: 5'd0, reg_write: 1'b0,
                              mem_read: 1'b0, is_link: 1'b0};

  // A record may forward only if it is real, writes, and does not target x0.
  function automatic logic is_producer(input rec_t r);
    return r.valid & r.reg_write & (r.rd != 5'd0);
  endfunction

  // Select for one operand; the younger EX producer shadows the MEM one.
  function automatic logic [1:0] operand_sel(input logic uses, input logic [4:0] rs,
                                             input rec_t ex, input rec_t mem);
    logic [1:0] s;
    s = 2'b00;
    if (!uses) begin
      s = 2'b00;
    end else if (is_producer(ex) && (ex.rd == rs)) begin
      s = ex.is_link ? 2'b11 : 2'b01;
    end else if (is_producer(mem) && (mem.rd == rs)) begin
      s = 2'b10;
    end else begin
      s = 2'b00;
    end
    return s;
  endfunction

  rec_t       ex_q, ex_d, mem_q, wb_q;
  state_e     state_q, state_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic       load_use_s;
  logic       stall_s, flush_s;
  rec_t       id_rec_s;

  assign id_rec_s = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write,
                      mem_read: id_mem_read, is_link: id_is_link};

  // Load-use hazard detection, stall FSM next state, EX record and select next values.
  always_comb begin
    load_use_s = 1'b0;
    stall_s    = 1'b0;
    flush_s    = 1'b0;
    state_d    = RUN;
    ex_d       = BUBBLE;
    fwd_a_d    = 2'b00;
    fwd_b_d    = 2'b00;

    if (id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
        ((id_uses_rs1 && (id_rs1 == ex_q.rd)) || (id_uses_rs2 && (id_rs2 == ex_q.rd)))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end

    // In STALL the load already sits in MEM behind a bubble, so any hazard
    // seen here comes from a different load and is handled exactly as in RUN.
    case (state_q)
      RUN:     state_d = load_use_s ? STALL : RUN;
      STALL:   state_d = load_use_s ? STALL : RUN;
      default: state_d = RUN;
    endcase

    if (ex_branch_taken) begin
      flush_s = 1'b1;
      stall_s = 1'b0;
      state_d = RUN;
    end else if (load_use_s) begin
      flush_s = 1'b1;
      stall_s = 1'b1;
    end else begin
      flush_s = 1'b0;
      stall_s = 1'b0;
    end

    if (!flush_s && id_valid) begin
      ex_d    = id_rec_s;
      fwd_a_d = operand_sel(id_uses_rs1, id_rs1, ex_q, mem_q);
      fwd_b_d = operand_sel(id_uses_rs2, id_rs2, ex_q, mem_q);
    end else begin
      ex_d    = BUBBLE;
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end
  end

  // Shadow pipeline records, stall state and registered forwarding selects.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      state_q <= RUN;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      state_q <= state_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;

  // Controls are forced to their idle values while reset is held so the
  // surrounding pipeline never sees a flush or stall from stale inputs.
  assign stall_if_id = reset_n & stall_s;
  assign pc_write_en = ~(reset_n & stall_s);
  assign flush_id_ex = reset_n & flush_s;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
  logic       id_reg_write = 1'b0, id_mem_read = 1'b0, id_is_link = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       stall_if_id, pc_write_en, flush_id_ex;

  hazard_forward_unit dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_is_link(id_is_link), .ex_branch_taken(ex_branch_taken),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_if_id(stall_if_id), .pc_write_en(pc_write_en), .flush_id_ex(flush_id_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit [4:0] rs1, rs2;
    bit       u1, u2;
    bit [4:0] rd;
    bit       wr, ld, lk;
  } ins_t;

  typedef struct {
    bit [1:0] sa, sb;
    bit       st, pc, fl;
    int       cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0, cyc = 0;

  // Reference model: the instructions that most recently entered EX and MEM,
  // plus the selects the instruction now in EX must see.
  ins_t     in_ex, in_mem;
  bit [1:0] m_sa = 2'd0, m_sb = 2'd0;

  function automatic ins_t mk(bit v, bit [4:0] rs1, bit u1, bit [4:0] rs2, bit u2,
                              bit [4:0] rd, bit wr, bit ld, bit lk);
    ins_t i;
    i.v = v; i.rs1 = rs1; i.u1 = u1; i.rs2 = rs2; i.u2 = u2;
    i.rd = rd; i.wr = wr; i.ld = ld; i.lk = lk;
    return i;
  endfunction

  function automatic bit writes(ins_t p, bit [4:0] r);
    return p.v && p.wr && p.rd != 5'd0 && p.rd == r;
  endfunction

  function automatic bit [1:0] ref_sel(bit u, bit [4:0] r);
    if (!u) return 2'd0;
    if (writes(in_ex, r)) return in_ex.lk ? 2'd3 : 2'd1;
    if (writes(in_mem, r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit ref_hazard(ins_t i);
    if (!i.v || !in_ex.v || !in_ex.ld || in_ex.rd == 5'd0) return 1'b0;
    return (i.u1 && i.rs1 == in_ex.rd) || (i.u2 && i.rs2 == in_ex.rd);
  endfunction

  // One clock cycle: drive inputs, queue the expected response, advance model.
  task automatic cycle(input ins_t i, input bit br, input bit rst_n_v, output bit stalled);
    exp_t e;
    bit   hz;
    ins_t nxt;
    bit [1:0] na, nb;
    id_valid = i.v; id_rs1 = i.rs1; id_rs2 = i.rs2; id_uses_rs1 = i.u1; id_uses_rs2 = i.u2;
    id_rd = i.rd; id_reg_write = i.wr; id_mem_read = i.ld; id_is_link = i.lk;
    ex_branch_taken = br;
    reset_n = rst_n_v;
    hz = ref_hazard(i);
    e.cyc = cyc;
    if (!rst_n_v) begin
      e.sa = 2'd0; e.sb = 2'd0; e.st = 1'b0; e.pc = 1'b1; e.fl = 1'b0;
      stalled = 1'b0;
    end else begin
      e.sa = m_sa; e.sb = m_sb;
      e.st = !br && hz; e.pc = !e.st; e.fl = br || hz;
      stalled = e.st;
    end
    exp_q.push_back(e);
    nxt = i; na = ref_sel(i.u1, i.rs1); nb = ref_sel(i.u2, i.rs2);
    if (!rst_n_v || br || hz || !i.v) begin
      nxt = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); na = 2'd0; nb = 2'd0;
    end
    @(posedge clk);
    if (!rst_n_v) begin
      in_mem = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      in_ex  = in_mem;
    end else begin
      in_mem = in_ex;
      in_ex  = nxt;
    end
    m_sa = na; m_sb = nb;
    cyc++;
    #1;
  endtask

  // Issue an instruction; a load-use stall keeps it in ID one more cycle.
  task automatic issue(input ins_t i, input bit br);
    bit st;
    cycle(i, br, 1'b1, st);
    if (st) cycle(i, 1'b0, 1'b1, st);
  endtask

  task automatic chk(string name, int got, int want, int c);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, c, got, want);
    end
  endtask

  // Monitor: at each falling edge compare outputs against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("fwd_a_sel", fwd_a_sel, e.sa, e.cyc);
        chk("fwd_b_sel", fwd_b_sel, e.sb, e.cyc);
        chk("stall_if_id", stall_if_id, e.st, e.cyc);
        chk("pc_write_en", pc_write_en, e.pc, e.cyc);
        chk("flush_id_ex", flush_id_ex, e.fl, e.cyc);
      end
    end
  end

  bit [4:0] regs [5] = '{5'd0, 5'd1, 5'd3, 5'd5, 5'd7};

  initial begin
    bit   st;
    ins_t nop, ri;
    int   wait_cnt;
    in_ex = mk(0, 0, 0, 0, 0, 0, 0, 0, 0); in_mem = in_ex;
    nop = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    cycle(mk(1, 3, 1, 3, 1, 3, 1, 0, 0), 1'b1, 1'b0, st);  // reset with busy inputs
    cycle(nop, 1'b0, 1'b0, st);
    // back-to-back ALU dependence
    issue(mk(1, 1, 1, 2, 1, 5, 1, 0, 0), 0);
    issue(mk(1, 5, 1, 0, 0, 9, 1, 0, 0), 0);
    issue(nop, 0); issue(nop, 0);
    // distance two, then EX-over-MEM priority
    issue(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), 0);
    issue(mk(1, 1, 1, 2, 1, 8, 1, 0, 0), 0);
    issue(mk(1, 0, 0, 7, 1, 9, 1, 0, 0), 0);
    issue(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), 0);
    issue(mk(1, 0, 0, 0, 0, 7, 1, 0, 0), 0);
    issue(mk(1, 0, 0, 7, 1, 9, 1, 0, 0), 0);
    issue(nop, 0); issue(nop, 0);
    // load-use
    issue(mk(1, 2, 1, 0, 0, 3, 1, 1, 0), 0);
    issue(mk(1, 3, 1, 0, 0, 9, 1, 0, 0), 0);
    issue(nop, 0); issue(nop, 0);
    // link and x0
    issue(mk(1, 0, 0, 0, 0, 1, 1, 0, 1), 0);
    issue(mk(1, 1, 1, 0, 0, 9, 1, 0, 0), 0);
    issue(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), 0);
    issue(mk(1, 0, 1, 0, 1, 9, 1, 0, 0), 0);
    issue(nop, 0); issue(nop, 0);
    // branch during load-use
    issue(mk(1, 2, 1, 0, 0, 3, 1, 1, 0), 0);
    issue(mk(1, 3, 1, 0, 0, 9, 1, 0, 0), 1);
    issue(mk(1, 3, 1, 0, 0, 9, 1, 0, 0), 0);
    issue(nop, 0); issue(nop, 0);
    // reset during the stall cycle
    issue(mk(1, 2, 1, 0, 0, 3, 1, 1, 0), 0);
    cycle(mk(1, 3, 1, 0, 0, 9, 1, 0, 0), 1'b0, 1'b1, st);
    cycle(mk(1, 3, 1, 0, 0, 9, 1, 0, 0), 1'b0, 1'b0, st);
    issue(mk(1, 3, 1, 0, 0, 9, 1, 0, 0), 0);
    issue(nop, 0); issue(nop, 0);
    // randomized traffic over a small register set to provoke overlaps
    for (int k = 0; k < 600; k++) begin
      ri.v  = ($urandom_range(0, 9) != 0);
      ri.rs1 = regs[$urandom_range(0, 4)];
      ri.rs2 = regs[$urandom_range(0, 4)];
      ri.u1 = $urandom_range(0, 3) != 0;
      ri.u2 = $urandom_range(0, 1);
      ri.rd = regs[$urandom_range(0, 4)];
      ri.lk = ($urandom_range(0, 9) == 0);
      ri.ld = !ri.lk && ($urandom_range(0, 3) == 0);
      ri.wr = ri.lk || ri.ld || ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) == 0) cycle(ri, 1'b0, 1'b0, st);
      else issue(ri, $urandom_range(0, 9) == 0);
    end
    issue(nop, 0);
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL have the following ports, one per line as name, direction, width, meaning, with clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  ID source register numbers.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2.
- id_rd  in  5  ID destination register number.
- id_reg_write  in  1  ID instruction writes rd.
- id_mem_read  in  1  ID instruction is a load.
- id_is_link  in  1  ID instruction is JAL/JALR, so rd receives PC+4.
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- fwd_a_sel, fwd_b_sel  out  2 each  registered select for EX operand A/B forwarding muxes.
- stall_if_id  out  1  hold IF/ID register.
- pc_write_en  out  1  PC may update.
- flush_id_ex  out  1  ID/EX register loads a bubble.

REQ-002 The forwarding selects SHALL use this encoding: 00 = register-file value, 01 = EX/MEM ALU result, 10 = MEM/WB writeback data, 11 = EX/MEM PC+4 (link value).

Function
REQ-003 The block SHALL keep three internal shadow records, EX, MEM and WB, each holding: valid, rd, reg_write, mem_read, is_link.
- Each cycle, EX advances to MEM and MEM advances to WB.
- EX loads the ID fields, or a bubble (valid=0), per REQ-008 and REQ-009.

REQ-004 A record SHALL qualify as a forwarding producer only if valid=1, reg_write=1 and rd!=0; register x0 never forwards.

REQ-005 For each ID source operand with uses=1, the block SHALL compute next_sel from the current records; these become the EX/MEM and MEM/WB stages when the instruction reaches EX.
- Current EX record qualifies, rd matches, is_link=1 -> 11.
- Current EX record qualifies, rd matches, otherwise -> 01.
- Else current MEM record qualifies and rd matches -> 10 (a link or load in MEM/WB also yields 10).
- Else -> 00.
- The EX match always takes priority over the MEM match.

REQ-006 fwd_a_sel/fwd_b_sel SHALL register next_sel on the edge at which the ID instruction enters EX.
- Latency: one cycle; the selects are valid for the whole EX cycle of that instruction.
- When a bubble enters EX, both selects register 00.

REQ-007 A load-use hazard SHALL be detected combinationally when id_valid=1, EX.valid=1, EX.mem_read=1, EX.rd!=0 and EX.rd matches any used ID source.

REQ-008 The stall state machine SHALL have two states, RUN and STALL.
- RUN, hazard and no ex_branch_taken: assert stall_if_id=1, pc_write_en=0, flush_id_ex=1; EX loads a bubble; go to STALL.
- STALL: the load has moved to MEM, so selects resolve to 10 and no further stall is raised by that load; return to RUN.
- A new, independent hazard in STALL SHALL be treated as in RUN.
- Stall length per load-use is exactly one cycle.

REQ-009 On ex_branch_taken=1, the block SHALL assert flush_id_ex=1; EX loads a bubble.
- It SHALL force stall_if_id=0 and pc_write_en=1, even if a load-use hazard is present.
- The state returns to RUN.
- Branch priority: flush beats stall.

REQ-010 When no stall is active, stall_if_id SHALL be 0 and pc_write_en SHALL be 1.
- stall_if_id, pc_write_en and flush_id_ex are combinational outputs.

REQ-011 When id_valid=0, the block SHALL raise no hazard and EX SHALL load a bubble.

Reset
REQ-012 While reset_n=0, asynchronously:
- all record valid bits are 0;
- fwd_a_sel and fwd_b_sel are 00;
- the state is RUN;
- outputs read stall_if_id=0, pc_write_en=1, flush_id_ex=0.

REQ-013 Reset asserted mid-stall SHALL abandon the stall immediately; after release, the first instruction sees no producers.

Verification
REQ-014 Back-to-back ALU dependence:
- Stimulus: add x5 (reg_write, rd=5), then rs1=5 consumer.
- Response: consumer's EX cycle has fwd_a_sel=01; no stall.

REQ-015 Distance-two dependence:
- Stimulus: producer rd=7, an independent instruction, then rs2=7.
- Response: fwd_b_sel=10.
- Variant: rd=7 in both EX and MEM gives 01 (priority).

REQ-016 Load-use:
- Stimulus: lw rd=3, then rs1=3.
- Response: one cycle with stall_if_id=1, pc_write_en=0, flush_id_ex=1, then fwd_a_sel=10; never two stall cycles.

REQ-017 Link and x0:
- Stimulus: jal rd=1, then rs1=1.
- Response: fwd_a_sel=11.
- Stimulus: producer rd=0 and consumer rs1=0.
- Response: fwd_a_sel=00.

REQ-018 Branch during load-use:
- Stimulus: lw rd=3 in EX, rs1=3 in ID, ex_branch_taken=1.
- Response: flush_id_ex=1, stall_if_id=0, pc_write_en=1; next EX cycle selects 00.

REQ-019 Reset mid-stall:
- Stimulus: reset_n low during the STALL cycle.
- Response: selects 00, stall_if_id=0; after release, rs1=3 gives 00.
